mult_sequencer: RTL and testbench

- Iterative signed 32x32 multiplier controller that runs radix-2 Booth steps through a single shared `cl_adder` instance.
- Sequences one add, subtract or skip step per cycle over 32 cycles.
- Returns the low 32 bits of the product plus an overflow exception.
- Sits beside the ALU in execute as the multiply unit, with a start-pulse / ready-pulse handshake toward the pipeline stall logic.

---
 rtl/mult_sequencer.sv | 178 +++++++++++++++++
 tb/tb_mult_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// Iterative signed WIDTHxWIDTH multiplier: radix-2 Booth, one add/sub/skip step per cycle through a shared adder.
// Latency: start sampled at edge 0, result_ready pulses in the cycle after edge 33 (32 Booth steps + one DONE cycle).
// Backpressure: none; ctrl_mult is ignored while busy and must be re-asserted in IDLE, nothing is queued.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   ctrl_mult             start pulse, only honoured in IDLE
//   operand_a, operand_b  signed multiplicand / multiplier, latched on an accepted start
//   busy                  high while an operation is in flight (RUN and DONE)
//   result, exception     low WIDTH bits of the product and the "does not fit" flag, held until the next result
//   result_ready          one-cycle pulse when result/exception are updated

module cl_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  localparam int LEVELS = $clog2(WIDTH);

  // Kogge-Stone prefix tree of (generate, propagate) pairs.
  logic [LEVELS:0][WIDTH-1:0] gen;
  logic [LEVELS:0][WIDTH-1:0] prop;
  logic [WIDTH:0]             carry;

  always_comb begin
    gen     = '0;
    prop    = '0;
    carry   = '0;
    gen[0]  = a & b;
    prop[0] = a ^ b;
    for (int l = 1; l <= LEVELS; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << (l - 1))) begin
          gen[l][i]  = gen[l-1][i] | (prop[l-1][i] & gen[l-1][i - (1 << (l - 1))]);
          prop[l][i] = prop[l-1][i] & prop[l-1][i - (1 << (l - 1))];
        end else begin
          gen[l][i]  = gen[l-1][i];
          prop[l][i] = prop[l-1][i];
        end
      end
    end
    // Each group prefix [0..i] either generates a carry or propagates cin.
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = gen[LEVELS][i] | (prop[LEVELS][i] & cin);
    end
  end

  assign sum      = prop[0] ^ carry[WIDTH-1:0];
  assign overflow = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_ready,
  output logic             exception
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH:0]   p;        // {upper, lower, q_1}
  logic [CNT_W-1:0]   counter;

  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH-1:0]   add_sum;
  logic               add_ovf;
  logic               shift_in;

  cl_adder #(.WIDTH(WIDTH)) u_adder (
    .a        (add_a),
    .b        (add_b),
    .cin      (add_cin),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  // True sign of the (WIDTH+1)-bit sum; sum[MSB] alone is wrong when the step overflows,
  // e.g. subtracting a most-negative multiplicand.
  assign shift_in = add_sum[WIDTH-1] ^ add_ovf;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = ctrl_mult ? RUN : IDLE;
      RUN:     state_next = (counter == CNT_W'(WIDTH - 1)) ? DONE : RUN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / adder-steering logic; the adder sees zeros outside RUN.
  always_comb begin
    busy    = (state != IDLE);
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a = p[2*WIDTH:WIDTH+1];
      case (p[1:0])
        2'b01: add_b = m;
        2'b10: begin
          add_b   = ~m;
          add_cin = 1'b1;
        end
        default: add_b = '0;
      endcase
    end
  end

  // Datapath and registered result outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      m            <= '0;
      p            <= '0;
      counter      <= '0;
      result       <= '0;
      result_ready <= 1'b0;
      exception    <= 1'b0;
    end else begin
      result_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_mult) begin
            m       <= operand_a;
            p       <= {{WIDTH{1'b0}}, operand_b, 1'b0};
            counter <= '0;
          end
        end
        RUN: begin
          p       <= {shift_in, add_sum, p[WIDTH:1]};
          counter <= counter + 1'b1;
        end
        DONE: begin
          result_ready <= 1'b1;
          result       <= p[WIDTH:1];
          exception    <= (p[2*WIDTH:WIDTH+1] != {WIDTH{p[WIDTH]}});
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_mult = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy;
  logic [31:0] result;
  logic        result_ready;
  logic        exception;

  mult_sequencer #(.WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .ctrl_mult    (ctrl_mult),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .busy         (busy),
    .result       (result),
    .result_ready (result_ready),
    .exception    (exception)
  );

  always #5 clock = ~clock;

  // Edge counter: after the k-th rising edge, cyc == k.
  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [31:0] r;
    logic        e;
    int          at_edge;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every result_ready pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (busy) busy_cnt++;
    if (result_ready) begin
      if (sb.size() == 0) begin
        check("spurious_result_ready", 32'(result_ready), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.r);
        check("exception", 32'(exception), 32'(mon_e.e));
        check("ready_edge", 32'(cyc), 32'(mon_e.at_edge));
      end
    end
  end

  task automatic expect_at(input logic [31:0] r, input logic e, input int at_edge);
    exp_t x;
    x.r = r;
    x.e = e;
    x.at_edge = at_edge;
    sb.push_back(x);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Single pulse start; operands scrambled right after the accepting edge.
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r, input logic e);
    @(negedge clock);
    operand_a = a;
    operand_b = b;
    ctrl_mult = 1'b1;
    expect_at(r, e, cyc + 34);
    @(negedge clock);
    ctrl_mult = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    drain();
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int s;
  int k;

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_result_ready", 32'(result_ready), 32'd0);
    check("rst_exception", 32'(exception), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Basic positive with busy-duration check
    busy_cnt = 0;
    op(32'd3, 32'd5, 32'h0000000F, 1'b0);
    check("busy_cycles", 32'(busy_cnt), 32'd33);

    // Signed, boundary and overflow vectors
    op(32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6, 1'b0);
    op(32'h80000000, 32'h00000001, 32'h80000000, 1'b0);
    op(32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
    op(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    op(32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b1);
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);

    // Busy protection: starts during RUN and in DONE are ignored, operand changes too
    @(negedge clock);
    operand_a = 32'd100;
    operand_b = 32'd100;
    ctrl_mult = 1'b1;
    s = cyc + 1;
    expect_at(32'h00002710, 1'b0, s + 33);
    @(negedge clock);
    ctrl_mult = 1'b0;
    while (cyc < s + 4) @(negedge clock);
    operand_a = 32'd2;
    operand_b = 32'd2;
    ctrl_mult = 1'b1;
    @(negedge clock);
    ctrl_mult = 1'b0;
    operand_a = 32'd3;
    operand_b = 32'd7;
    while (cyc < s + 32) @(negedge clock);
    ctrl_mult = 1'b1;   // sampled at the DONE edge
    @(negedge clock);
    ctrl_mult = 1'b0;
    drain();
    repeat (40) @(negedge clock);
    check("no_restart_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a run
    @(negedge clock);
    operand_a = 32'h00001234;
    operand_b = 32'h00005678;
    ctrl_mult = 1'b1;
    s = cyc + 1;
    @(negedge clock);
    ctrl_mult = 1'b0;
    while (cyc < s + 10) begin
      @(posedge clock);
      #1;
    end
    #1;
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_result_ready", 32'(result_ready), 32'd0);
    check("abort_exception", 32'(exception), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    op(32'd9, 32'd9, 32'h00000051, 1'b0);

    // Back-to-back with ctrl_mult held high
    @(negedge clock);
    operand_a = 32'd2;
    operand_b = 32'd3;
    ctrl_mult = 1'b1;
    k = cyc;
    expect_at(32'd6, 1'b0, k + 34);
    @(negedge clock);
    operand_a = 32'd4;
    operand_b = 32'd5;
    expect_at(32'd20, 1'b0, k + 68);
    while (cyc < k + 35) @(negedge clock);
    ctrl_mult = 1'b0;
    while (cyc < k + 50) @(negedge clock);
    check("b2b_result_held", result, 32'd6);
    drain();
    repeat (5) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
